// File: rtl/beep_pkg.sv
// Shared types and default timing for the buzzer pattern sequencer.
// Defaults assume a 50 MHz clock.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int CLK_HZ        = 50_000_000;
    localparam int TONE_HALF_DEF = CLK_HZ / 4000;  // 2 kHz tone
    localparam int ON_CYC_DEF    = CLK_HZ / 10;    // 0.1 s burst
    localparam int OFF_CYC_DEF   = CLK_HZ / 10;    // 0.1 s gap

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: tone restarts high on clr and toggles every HALF enabled cycles.
// tone_next exposes the level the tone register takes at the coming edge.
module tone_div #(
    parameter int HALF = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tone_next
);
    localparam int CW = $clog2(HALF + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          tone_reg;

    always_comb begin
        cnt_next  = cnt_reg;
        tone_next = tone_reg;
        if (clr) begin
            cnt_next  = '0;
            tone_next = 1'b1;
        end else if (en) begin
            if (cnt_reg == CW'(HALF - 1)) begin
                cnt_next  = '0;
                tone_next = ~tone_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            tone_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            tone_reg <= tone_next;
        end
    end

endmodule

// File: rtl/beep_seq.sv
// Plays beep_cnt tone bursts on each rising edge of the timer full flag,
// with busy/done status and a remaining-burst count.
module beep_seq
    import beep_pkg::*;
#(
    parameter int TONE_HALF = TONE_HALF_DEF,
    parameter int ON_CYC    = ON_CYC_DEF,
    parameter int OFF_CYC   = OFF_CYC_DEF,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] beep_cnt,
    input  logic             mute,
    output logic             buzzer,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] beeps_left
);
    localparam int DW = $clog2(max2(ON_CYC, OFF_CYC) + 1);

    state_t           state_reg;
    logic             trig_q;
    logic [DW-1:0]    dur_reg;
    logic [CNT_W-1:0] beeps_left_reg;
    logic             buzzer_reg;
    logic             done_reg;

    logic trig_evt;
    logic start;
    logic on_last;
    logic off_last;
    logic tone_clr;
    logic tone_en;
    logic tone_next;

    assign trig_evt = trig & ~trig_q;
    assign start    = (state_reg == IDLE) && trig_evt && (beep_cnt != '0);
    assign on_last  = (state_reg == ON)  && (dur_reg == DW'(ON_CYC - 1));
    assign off_last = (state_reg == OFF) && (dur_reg == DW'(OFF_CYC - 1));

    // Clearing on every ON entry gives each burst the same starting phase.
    assign tone_clr = start | off_last;
    assign tone_en  = (state_reg == ON);

    tone_div #(
        .HALF(TONE_HALF)
    ) u_tone_div (
        .clk       (clk),
        .rst       (rst),
        .clr       (tone_clr),
        .en        (tone_en),
        .tone_next (tone_next)
    );

    // buzzer is computed from the next state so the first ON cycle is already high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            trig_q         <= 1'b0;
            dur_reg        <= '0;
            beeps_left_reg <= '0;
            buzzer_reg     <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            trig_q     <= trig;
            done_reg   <= 1'b0;
            buzzer_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= ON;
                        dur_reg        <= '0;
                        beeps_left_reg <= beep_cnt;
                        buzzer_reg     <= ~mute;
                    end
                end
                ON: begin
                    if (on_last) begin
                        dur_reg <= '0;
                        if (beeps_left_reg > CNT_W'(1)) begin
                            beeps_left_reg <= beeps_left_reg - 1'b1;
                            state_reg      <= OFF;
                        end else begin
                            beeps_left_reg <= '0;
                            state_reg      <= IDLE;
                            done_reg       <= 1'b1;
                        end
                    end else begin
                        dur_reg    <= dur_reg + 1'b1;
                        buzzer_reg <= tone_next & ~mute;
                    end
                end
                OFF: begin
                    if (off_last) begin
                        dur_reg    <= '0;
                        state_reg  <= ON;
                        buzzer_reg <= ~mute;
                    end else begin
                        dur_reg <= dur_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign buzzer     = buzzer_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign beeps_left = beeps_left_reg;

endmodule

// File: doc/beep_seq.md
# beep_seq

Buzzer pattern sequencer that sits directly downstream of the interval timer. It consumes the timer's full/terminal-count flag and, on each rising edge of that flag, plays a programmable number of tone bursts on a piezo buzzer pin. Each burst is a square wave with fixed on and off durations. It reports busy/done status back to the control logic.

## Interface
Parameters:
- TONE_HALF, 12500: clocks per half period of the tone square wave (2 kHz at 50 MHz); must be ≥1.
- ON_CYC, 5_000_000: clocks per burst (0.1 s); must be ≥1.
- OFF_CYC, 5_000_000: clocks of silence between bursts; must be ≥1.
- CNT_W, 4: width of the beep-count input.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. One clock domain; synchronous, active-high.
- trig, input, 1: timer full flag. It is rising-edge detected internally.
- beep_cnt, input, CNT_W: number of bursts. Sampled only at an accepted trigger.
- mute, input, 1: forces buzzer low. Sequencing is unaffected.
- buzzer, output, 1: registered tone output.
- busy, output, 1: high while a sequence is playing.
- done, output, 1: one-cycle pulse when a sequence completes.
- beeps_left, output, CNT_W: bursts remaining, including the current burst.

## Operation
- Edge detect: trig_q is a registered copy of trig. The trigger event is `trig & ~trig_q`. trig_q resets to 0, so trig already high at reset release counts as an edge.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - Trigger event with beep_cnt≠0: latch beeps_left=beep_cnt, clear the duration and tone counters, go to ON.
  - Trigger event with beep_cnt=0: ignored, stay in IDLE, no done pulse.
- ON:
  - Duration counter runs 0..ON_CYC-1.
  - Tone divider toggles the tone every TONE_HALF clocks, starting high.
  - At the last cycle: if beeps_left>1, decrement beeps_left and go to OFF. Otherwise set beeps_left=0, go to IDLE and pulse done.
- OFF:
  - Tone is held low for OFF_CYC clocks, then go to ON.
  - The tone counter is cleared on ON entry, so every burst starts high with identical phase.
- Trigger events in ON or OFF are ignored. No queuing, no restart.
- buzzer = tone & (state==ON) & ~mute, registered.
- busy = (state!=IDLE).
- Widths: counters are $clog2(param+1) bits and compare against param-1. beeps_left decrements are never taken below 0.
- Reset values: state IDLE, buzzer 0, busy 0, done 0, beeps_left 0, trig_q 0, all counters 0.
- rst asserted mid-sequence: all outputs return to their reset values on the next edge. No done pulse is produced.

## Timing
- Trigger sampled at edge t: state ON, busy=1 and buzzer=1 (unmuted) from cycle t+1.
- Each burst occupies exactly ON_CYC cycles. Each gap occupies exactly OFF_CYC cycles.
- Total busy time for N bursts: N·ON_CYC + (N-1)·OFF_CYC cycles.
- done is high for the single cycle immediately after the last ON cycle, with busy=0 in that cycle.
- A trigger event in the done cycle is accepted: the next sequence starts the following cycle.
- mute takes effect on buzzer one cycle after it changes. It has no effect on busy, done or beeps_left timing.

## Structure
- Package beep_pkg:
  - State enum (IDLE/ON/OFF).
  - Default constants CLK_HZ=50_000_000, TONE_HALF_DEF, ON_CYC_DEF, OFF_CYC_DEF.
- Sub-module tone_div:
  - Square-wave divider with clr and en inputs; parameter HALF.
  - Outputs a tone that starts high after clr and toggles every HALF enabled cycles.
- beep_seq holds the edge detector, the FSM, the duration counter and beeps_left.

## Test plan
Bench parameters: TONE_HALF=2, ON_CYC=8, OFF_CYC=4.
- **Three bursts:** beep_cnt=3, single-cycle trig at edge t.
  - buzzer pattern 1100_1100 in cycles t+1..t+8, t+13..t+20 and t+25..t+32; 0 elsewhere.
  - busy high t+1..t+32; done pulse at t+33.
  - beeps_left reads 3, 2, 1 during the three bursts, then 0.
- **Zero count:** beep_cnt=0 with a trig pulse → busy, buzzer and done stay 0 for 50 cycles.
- **Held trigger:** trig held high for 60 cycles with beep_cnt=2 → exactly one sequence (done at t+21), no second start. Separately, a trig pulse at t+10 during the sequence is ignored.
- **Reset mid-burst:** rst asserted at t+5 of a 3-burst sequence → next cycle buzzer=0, busy=0, beeps_left=0. No done pulse; FSM idle.
- **Mute:** mute=1 over t+1..t+40 with beep_cnt=2 → buzzer stays 0. busy and done timing are identical to unmuted (done at t+21).
- **Back-to-back:** trig edge in the done cycle (t+21, beep_cnt=1) → new burst with buzzer=1 at t+22, done at t+30.
